// File: rtl/uart_lite_pkg.sv
// Shared definitions for the UART-lite receive path: flag layout, event classes
// and sizing helpers.
package uart_lite_pkg;

  localparam int unsigned FLAG_PARITY = 0;
  localparam int unsigned FLAG_FRAME  = 1;
  localparam int unsigned FLAG_BITS   = 2;

  typedef enum logic [2:0] {
    EV_NONE,
    EV_DATA,
    EV_PARITY,
    EV_FRAME,
    EV_BREAK
  } rx_event_e;

  // Buffer entry: character followed by its two flag bits.
  function automatic int unsigned entry_width(input int unsigned data_bits);
    return data_bits + FLAG_BITS;
  endfunction

  // Idle time, in clocks, of a given number of full character frames.
  function automatic int unsigned timeout_len(input int unsigned chars,
                                              input int unsigned oversampling,
                                              input int unsigned data_bits);
    return chars * oversampling * (data_bits + 2);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous FIFO for received characters; accepts push and pop together when full.
module uart_rx_fifo #(
  parameter int unsigned WIDTH = 10,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wdata,
  output logic [WIDTH-1:0]           rdata,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [LW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == LW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & (~full | pop);
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];
  assign level   = count;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + LW'(1);
        2'b01:   count <= count - LW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset; entries are only read behind a valid count.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/uart_rx_controller.sv
// Receive-side controller: classifies character_recovery pulses into a buffered,
// flag-tagged stream and tracks overrun/break/idle-timeout status.
// Optional idle timeout enabled by defining UART_RX_TIMEOUT_EN.
module uart_rx_controller
  import uart_lite_pkg::*;
#(
  parameter int unsigned DATA_BITS     = 8,
  parameter int unsigned FIFO_DEPTH    = 8,
  parameter int unsigned OVERSAMPLING  = 16,
  parameter int unsigned TIMEOUT_CHARS = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          enable_i,
  output logic                          rec_rst_o,
  input  logic [DATA_BITS-1:0]          rec_char_i,
  input  logic                          rec_valid_i,
  input  logic                          rec_frame_error_i,
  input  logic                          rec_parity_error_i,
  output logic [DATA_BITS-1:0]          data_o,
  output logic [1:0]                    flags_o,
  output logic                          data_valid_o,
  input  logic                          data_ready_i,
  output logic [$clog2(FIFO_DEPTH):0]   level_o,
  output logic                          overrun_o,
  input  logic                          clear_overrun_i,
  output logic                          break_o,
  output logic                          timeout_o
);

  localparam int unsigned EW          = entry_width(DATA_BITS);
  localparam int unsigned TIMEOUT_LEN = timeout_len(TIMEOUT_CHARS, OVERSAMPLING, DATA_BITS);

  if (TIMEOUT_LEN == 0 || FIFO_DEPTH < 2 || (1 << $clog2(FIFO_DEPTH)) != FIFO_DEPTH)
  begin : g_param_check
    $error("uart_rx_controller: invalid FIFO_DEPTH or timeout parameters");
  end

  rx_event_e      ev;
  logic           push_req;
  logic [1:0]     wflags;
  logic [EW-1:0]  wentry;
  logic [EW-1:0]  rentry;
  logic           pop;
  logic           full;
  logic           empty;

  assign rec_rst_o = rst_i | ~enable_i;

  // One event per cycle; the core never pairs valid with an error.
  always_comb begin
    ev       = EV_NONE;
    push_req = 1'b0;
    wflags   = '0;
    if (enable_i) begin
      if (rec_valid_i)             ev = EV_DATA;
      else if (rec_parity_error_i) ev = EV_PARITY;
      else if (rec_frame_error_i)  ev = (rec_char_i == '0) ? EV_BREAK : EV_FRAME;
    end
    push_req            = (ev == EV_DATA) || (ev == EV_PARITY) || (ev == EV_FRAME);
    wflags[FLAG_PARITY] = (ev == EV_PARITY);
    wflags[FLAG_FRAME]  = (ev == EV_FRAME);
  end

  assign wentry       = {rec_char_i, wflags};
  assign pop          = ~empty & data_ready_i;
  assign data_valid_o = ~empty;
  assign data_o       = rentry[EW-1:FLAG_BITS];
  assign flags_o      = rentry[FLAG_BITS-1:0];

  uart_rx_fifo #(
    .WIDTH (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (push_req),
    .pop   (pop),
    .wdata (wentry),
    .rdata (rentry),
    .level (level_o),
    .full  (full),
    .empty (empty)
  );

  // Sticky overrun (drop wins over clear) and break status.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      overrun_o <= 1'b0;
      break_o   <= 1'b0;
    end else begin
      if (push_req && full && !pop) overrun_o <= 1'b1;
      else if (clear_overrun_i)     overrun_o <= 1'b0;

      if (ev == EV_BREAK)     break_o <= 1'b1;
      else if (ev == EV_DATA) break_o <= 1'b0;
    end
  end

`ifdef UART_RX_TIMEOUT_EN
  localparam int unsigned IW = $clog2(TIMEOUT_LEN) + 1;

  logic [IW-1:0] idle_cnt;

  // Saturating idle counter, restarted by any push or an empty buffer.
  always_ff @(posedge clk_i) begin
    if (rst_i || push_req || empty) idle_cnt <= '0;
    else if (idle_cnt != IW'(TIMEOUT_LEN)) idle_cnt <= idle_cnt + IW'(1);
  end

  assign timeout_o = (idle_cnt == IW'(TIMEOUT_LEN)) & ~empty;
`else
  assign timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_controller.sv
// Directed and randomized bench for uart_rx_controller against a queue-based reference model.
module tb_uart_rx_controller;

  localparam int DEPTH = 8;
  localparam int T     = 4 * 16 * (8 + 2);

  logic       clk = 1'b0;
  logic       rst_i, enable_i, rec_rst_o;
  logic [7:0] rec_char_i;
  logic       rec_valid_i, rec_frame_error_i, rec_parity_error_i;
  logic [7:0] data_o;
  logic [1:0] flags_o;
  logic       data_valid_o, data_ready_i;
  logic [3:0] level_o;
  logic       overrun_o, clear_overrun_i, break_o, timeout_o;

  int n_cmp = 0;
  int n_err = 0;

  logic [9:0] q[$];
  bit         m_ovr = 0;
  bit         m_brk = 0;
  int         m_idle = 0;

  always #5 clk = ~clk;

  uart_rx_controller dut (
    .clk_i              (clk),
    .rst_i              (rst_i),
    .enable_i           (enable_i),
    .rec_rst_o          (rec_rst_o),
    .rec_char_i         (rec_char_i),
    .rec_valid_i        (rec_valid_i),
    .rec_frame_error_i  (rec_frame_error_i),
    .rec_parity_error_i (rec_parity_error_i),
    .data_o             (data_o),
    .flags_o            (flags_o),
    .data_valid_o       (data_valid_o),
    .data_ready_i       (data_ready_i),
    .level_o            (level_o),
    .overrun_o          (overrun_o),
    .clear_overrun_i    (clear_overrun_i),
    .break_o            (break_o),
    .timeout_o          (timeout_o)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_outputs();
    bit exp_to;
`ifdef UART_RX_TIMEOUT_EN
    exp_to = (m_idle == T) && (q.size() != 0);
`else
    exp_to = 1'b0;
`endif
    check("level", 32'(level_o), 32'(q.size()));
    check("data_valid", 32'(data_valid_o), 32'(q.size() != 0));
    check("overrun", 32'(overrun_o), 32'(m_ovr));
    check("break", 32'(break_o), 32'(m_brk));
    check("timeout", 32'(timeout_o), 32'(exp_to));
    if (q.size() != 0) begin
      check("head_data", 32'(data_o), 32'(q[0][9:2]));
      check("head_flags", 32'(flags_o), 32'(q[0][1:0]));
    end
  endtask

  // ev: 0 none, 1 valid, 2 parity error, 3 frame error. Called at a falling edge.
  task automatic step(input bit r, input bit en, input int ev, input logic [7:0] ch,
                      input bit rdy, input bit clr);
    int         sz;
    bit         pop_m, push_m, ovr_set;
    logic [9:0] ent;
    check_outputs();
    rst_i              = r;
    enable_i           = en;
    rec_valid_i        = (ev == 1);
    rec_parity_error_i = (ev == 2);
    rec_frame_error_i  = (ev == 3);
    rec_char_i         = ch;
    data_ready_i       = rdy;
    clear_overrun_i    = clr;
    #1;
    check("rec_rst", 32'(rec_rst_o), 32'(r | !en));

    sz      = q.size();
    pop_m   = (sz != 0) && rdy;
    push_m  = !r && en && (ev == 1 || ev == 2 || (ev == 3 && ch != 0));
    ovr_set = 0;
    ent     = {ch, (ev == 3) ? 2'b10 : (ev == 2) ? 2'b01 : 2'b00};
    if (r) begin
      q.delete();
      m_ovr  = 0;
      m_brk  = 0;
      m_idle = 0;
    end else begin
      if (pop_m) void'(q.pop_front());
      if (push_m) begin
        if (sz < DEPTH || pop_m) q.push_back(ent);
        else ovr_set = 1;
      end
      if (ovr_set) m_ovr = 1;
      else if (clr) m_ovr = 0;
      if (en && ev == 3 && ch == 0) m_brk = 1;
      else if (en && ev == 1) m_brk = 0;
      if (push_m || sz == 0) m_idle = 0;
      else if (m_idle < T) m_idle++;
    end
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] first_out, last_out;
    rst_i = 1; enable_i = 0; rec_char_i = 0; rec_valid_i = 0;
    rec_frame_error_i = 0; rec_parity_error_i = 0; data_ready_i = 0; clear_overrun_i = 0;
    @(negedge clk);

    step(1, 0, 0, 8'h00, 0, 0);
    step(1, 1, 1, 8'hEE, 0, 0);
    check("reset_level", 32'(level_o), 0);
    check("reset_valid", 32'(data_valid_o), 0);

    // Single character, then pop.
    step(0, 1, 1, 8'hA5, 0, 0);
    check("a5_data", 32'(data_o), 32'h A5);
    check("a5_flags", 32'(flags_o), 0);
    check("a5_level", 32'(level_o), 1);
    step(0, 1, 0, 8'h00, 1, 0);
    check("a5_pop_level", 32'(level_o), 0);

    // Parity then frame error entries, in order.
    step(0, 1, 2, 8'h3C, 0, 0);
    step(0, 1, 3, 8'h81, 0, 0);
    check("par_head", 32'({data_o, flags_o}), 32'({8'h3C, 2'b01}));
    step(0, 1, 0, 8'h00, 1, 0);
    check("frm_head", 32'({data_o, flags_o}), 32'({8'h81, 2'b10}));
    step(0, 1, 0, 8'h00, 1, 0);

    // Overfill: nine pushes into eight entries.
    for (int i = 0; i < 9; i++) step(0, 1, 1, 8'(i), 0, 0);
    check("ovf_level", 32'(level_o), 8);
    check("ovf_flag", 32'(overrun_o), 1);
    check("ovf_head", 32'(data_o), 0);
    step(0, 1, 1, 8'h09, 0, 1);
    check("ovf_set_wins", 32'(overrun_o), 1);
    step(0, 1, 0, 8'h00, 0, 1);
    check("ovf_cleared", 32'(overrun_o), 0);

    // Push and pop together while full.
    step(0, 1, 1, 8'h55, 1, 0);
    check("full_pp_level", 32'(level_o), 8);
    check("full_pp_ovr", 32'(overrun_o), 0);
    first_out = data_o;
    last_out  = 8'h00;
    for (int i = 0; i < 8; i++) begin
      last_out = data_o;
      step(0, 1, 0, 8'h00, 1, 0);
    end
    check("drain_first", 32'(first_out), 32'h01);
    check("drain_tail", 32'(last_out), 32'h55);

    // Break detection and clear.
    step(0, 1, 2, 8'h10, 0, 0);
    step(0, 1, 3, 8'h00, 0, 0);
    check("break_set", 32'(break_o), 1);
    check("break_level", 32'(level_o), 1);
    step(0, 1, 1, 8'h41, 0, 0);
    check("break_clr", 32'(break_o), 0);
    check("break_tail_level", 32'(level_o), 2);
    step(0, 1, 0, 8'h00, 1, 0);
    check("after_break_head", 32'(data_o), 32'h41);
    step(0, 1, 0, 8'h00, 1, 0);

`ifdef UART_RX_TIMEOUT_EN
    step(0, 1, 1, 8'h77, 0, 0);
    for (int i = 0; i < T - 1; i++) step(0, 1, 0, 8'h00, 0, 0);
    check("to_639", 32'(timeout_o), 0);
    step(0, 1, 0, 8'h00, 0, 0);
    check("to_640", 32'(timeout_o), 1);
    step(0, 1, 0, 8'h00, 1, 0);
    check("to_pop", 32'(timeout_o), 0);
`endif

    // Disabled receiver ignores the core.
    step(0, 1, 1, 8'h12, 0, 0);
    step(0, 0, 1, 8'h34, 0, 0);
    step(0, 0, 3, 8'h00, 0, 0);
    check("dis_level", 32'(level_o), 1);
    check("dis_break", 32'(break_o), 0);
    step(0, 0, 0, 8'h00, 1, 0);
    check("dis_pop", 32'(level_o), 0);

    // Randomized traffic.
    for (int i = 0; i < 4000; i++) begin
      bit         r, en, rdy, clr;
      int         ev;
      logic [7:0] ch;
      r   = ($urandom_range(0, 199) == 0);
      en  = ($urandom_range(0, 9) != 0);
      ev  = int'($urandom_range(0, 3));
      ch  = 8'($urandom);
      if (ev == 3 && $urandom_range(0, 3) == 0) ch = 8'h00;
      rdy = ($urandom_range(0, 2) == 0);
      clr = en && ($urandom_range(0, 15) == 0);
      step(r, en, ev, ch, rdy, clr);
    end
    step(0, 1, 0, 8'h00, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx_controller.md
Name: uart_rx_controller

Overview:
- Receive-side controller wrapped around character_recovery.
- Gates the recovery core on and off through its reset.
- Turns its single-cycle char/valid/error pulses into a buffered, flag-tagged stream with a valid/ready handshake.
- Maintains overrun, break and idle-timeout status for the host-facing register layer.

Parameters:
- DATA_BITS, 8: character width; must match the character_recovery instance.
- FIFO_DEPTH, 8: receive buffer entries; power of two, minimum 2.
- OVERSAMPLING, 16: clocks per bit; used only for the timeout length.
- TIMEOUT_CHARS, 4: idle character times before timeout_o asserts.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous active-high reset
- enable_i  in  1  receiver enable
- rec_rst_o  out  1  reset to character_recovery
- rec_char_i  in  DATA_BITS  character_recovery char_o
- rec_valid_i  in  1  character_recovery valid_o
- rec_frame_error_i  in  1  character_recovery frame_error_o
- rec_parity_error_i  in  1  character_recovery parity_error_o
- data_o  out  DATA_BITS  head-of-buffer character
- flags_o  out  2  head-of-buffer flags {frame_error, parity_error}
- data_valid_o  out  1  buffer non-empty
- data_ready_i  in  1  consumer accepts head
- level_o  out  $clog2(FIFO_DEPTH)+1  entries held
- overrun_o  out  1  sticky: event dropped while full
- clear_overrun_i  in  1  clears overrun_o
- break_o  out  1  break condition present
- timeout_o  out  1  idle timeout with data pending

Behaviour:
- Reset (rst_i=1): buffer empty, level_o=0, data_valid_o=0, overrun_o=0, break_o=0, timeout_o=0. data_o/flags_o are don't-care while data_valid_o=0.
- rec_rst_o = rst_i | ~enable_i, combinational, so the core restarts cleanly on every enable rising edge.
- While enable_i=0:
  - all rec_* inputs are ignored;
  - buffer contents are retained and can still be popped;
  - status bits hold.
- Event classification, one per cycle; the core never asserts rec_valid_i together with an error.
  - rec_valid_i: push {char, 2'b00}; clear break_o.
  - rec_parity_error_i: push {char, 2'b01}.
  - rec_frame_error_i with rec_char_i != 0: push {char, 2'b10}.
  - rec_frame_error_i with rec_char_i == 0: break. Set break_o and do not push.
- Pop: occurs when data_valid_o & data_ready_i. The head advances on the next edge.
- Latency: a push becomes visible on data_o/data_valid_o one cycle later. There is no fall-through.
- Full buffer:
  - push without a pop in the same cycle: drop the event and set overrun_o;
  - push and pop in the same cycle: both occur, level unchanged, no overrun.
- Empty buffer with push in the same cycle: data_ready_i is irrelevant because data_valid_o=0; the push occurs.
- overrun_o: set and clear_overrun_i in the same cycle, set wins. Otherwise clear_overrun_i clears it.
- level_o ranges 0..FIFO_DEPTH. Pointers are $clog2(FIFO_DEPTH) bits and wrap modulo depth.
- Reset mid-character: the core is reset via rec_rst_o and the buffer is flushed. No partial character is ever pushed.

Optional Feature:
- Macro: UART_RX_TIMEOUT_EN.
- With the macro defined:
  - idle counter width is $clog2(T)+1, where T = TIMEOUT_CHARS*OVERSAMPLING*(DATA_BITS+2) (default 640);
  - the counter resets to 0 on any push, on a buffer-empty cycle, or on rst_i;
  - otherwise it increments and saturates at T;
  - timeout_o = (count == T) & data_valid_o.
- Without the macro: timeout_o is tied to 0 and no counter is instantiated.

Decomposition:
- Package uart_lite_pkg:
  - flag bit indices FLAG_PARITY=0 and FLAG_FRAME=1;
  - entry width function DATA_BITS+2;
  - timeout length function.
- Sub-module uart_rx_fifo: synchronous FIFO with parameters WIDTH and DEPTH.
  - Ports: push, pop, wdata, rdata, level, full, empty.
  - Simultaneous push and pop when full is permitted.
- The controller holds classification, status and timeout logic only.

Test Plan:
- Reset, enable_i=1, then rec_valid_i with char 8'hA5 → next cycle data_valid_o=1, data_o=8'hA5, flags_o=2'b00, level_o=1. Pop → level_o=0.
- rec_parity_error_i with 8'h3C, then rec_frame_error_i with 8'h81 → entries {3C,01} then {81,10}, in order.
- 9 rec_valid_i pulses (8'h00..8'h08), data_ready_i=0, depth 8 → level_o=8, overrun_o=1, head 8'h00, 8'h08 absent. clear_overrun_i together with a new drop → overrun_o stays 1.
- Full buffer, rec_valid_i 8'h55 with data_ready_i=1 in the same cycle → level_o stays 8, overrun_o=0, tail=8'h55.
- rec_frame_error_i with char 8'h00 → break_o=1, level_o unchanged. Later rec_valid_i 8'h41 → break_o=0, 8'h41 buffered.
- With UART_RX_TIMEOUT_EN: one char buffered, idle for 639 cycles → timeout_o=0; at 640 cycles → timeout_o=1. Pop → 0. enable_i=0 → rec_rst_o=1 and rec inputs ignored.
